gate_response_checker: RTL and testbench

//  Self-test engine for the two-input basic-gates block: drives the gate inputs (a,b) through all

---
 rtl/gate_chk_pkg.sv | 24 ++
 rtl/gate_expect.sv | 22 ++
 rtl/gate_response_checker.sv | 147 ++++++++++++++
 tb/tb_gate_response_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared widths, FSM state encoding and gate_in bit positions
// for the gate response checker.
package gate_chk_pkg;

  localparam int GATE_W  = 7;
  localparam int NUM_VEC = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // gate_in ordering {xnor,xor,nor,nand,or,and,b_not}, bit6..bit0
  localparam int BIT_BNOT = 0;
  localparam int BIT_AND  = 1;
  localparam int BIT_OR   = 2;
  localparam int BIT_NAND = 3;
  localparam int BIT_NOR  = 4;
  localparam int BIT_XOR  = 5;
  localparam int BIT_XNOR = 6;

  typedef logic [GATE_W-1:0] gate_vec_t;

endpackage

// File: rtl/gate_expect.sv
// gate_expect: combinational reference for the seven outputs of the basic-gates
// block for a single (a,b) input pair.
module gate_expect
  import gate_chk_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output gate_vec_t exp
);

  always_comb begin
    exp           = '0;
    exp[BIT_BNOT] = ~b;
    exp[BIT_AND]  = a & b;
    exp[BIT_OR]   = a | b;
    exp[BIT_NAND] = ~(a & b);
    exp[BIT_NOR]  = ~(a | b);
    exp[BIT_XOR]  = a ^ b;
    exp[BIT_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: sweeps (a,b) through 00,01,10,11 and checks the gates block outputs.
// Define GATE_CHK_CAPTURE_EN to add first_fail_vec/first_syndrome capture of the first failure.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [GATE_W-1:0]  gate_in,
  output logic               a_out,
  output logic               b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_count,
  output logic [NUM_VEC-1:0] fail_mask
`ifdef GATE_CHK_CAPTURE_EN
  ,
  output logic [1:0]         first_fail_vec,
  output logic [GATE_W-1:0]  first_syndrome
`endif
);

  logic [1:0]         r_state;
  logic [1:0]         r_vec;
  logic [7:0]         r_settle;
  logic               r_a;
  logic               r_b;
  logic               r_pass;
  logic [2:0]         r_err;
  logic [NUM_VEC-1:0] r_mask;

  gate_vec_t          w_exp;
  logic               w_mismatch;
  logic [2:0]         w_errNext;
  logic               w_settleLast;
  logic [1:0]         w_vecNext;

  gate_expect uExpect (
    .a   (r_vec[1]),
    .b   (r_vec[0]),
    .exp (w_exp)
  );

  // Four-state compare so an X or Z on gate_in is reported as a failure
  assign w_mismatch   = (gate_in !== w_exp);
  assign w_errNext    = r_err + {2'b00, w_mismatch};
  assign w_settleLast = (r_settle == 8'(SETTLE_CYCLES - 1));
  assign w_vecNext    = r_vec + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_vec    <= 2'd0;
      r_settle <= 8'd0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= 3'd0;
      r_mask   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err    <= 3'd0;
            r_mask   <= '0;
            r_pass   <= 1'b0;
            r_vec    <= 2'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_settle <= 8'd0;
            r_state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (w_settleLast) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + 8'd1;
          end
        end
        ST_SAMPLE: begin
          r_err <= w_errNext;
          if (w_mismatch) begin
            r_mask[r_vec] <= 1'b1;
          end
          // Pass is decided here so it is already valid during the done cycle
          if (r_vec == 2'd3) begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_pass  <= (w_errNext == 3'd0);
            r_state <= ST_DONE;
          end else begin
            r_vec    <= w_vecNext;
            r_a      <= w_vecNext[1];
            r_b      <= w_vecNext[0];
            r_settle <= 8'd0;
            r_state  <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_mask = r_mask;

`ifdef GATE_CHK_CAPTURE_EN
  logic      r_captured;
  logic [1:0] r_firstVec;
  gate_vec_t r_firstSyn;

  // Only the first failing sample of a sweep is recorded; later failures leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_captured <= 1'b0;
      r_firstVec <= 2'd0;
      r_firstSyn <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_captured <= 1'b0;
      r_firstVec <= 2'd0;
      r_firstSyn <= '0;
    end else if ((r_state == ST_SAMPLE) && w_mismatch && !r_captured) begin
      r_captured <= 1'b1;
      r_firstVec <= r_vec;
      r_firstSyn <= gate_in ^ w_exp;
    end
  end

  assign first_fail_vec = r_firstVec;
  assign first_syndrome = r_firstSyn;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: three checkers (SETTLE_CYCLES 1, 2, 5) run side by side against a
// faultable gates model; every output is compared each cycle to a sweep-level reference.
module tb_gate_response_checker;

  localparam int NDUT    = 3;
  localparam int LASTCYC = 28;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [6:0] forceMask;
  logic [6:0] forceVal;

  logic [NDUT-1:0]      aOut;
  logic [NDUT-1:0]      bOut;
  logic [NDUT-1:0]      busyOut;
  logic [NDUT-1:0]      doneOut;
  logic [NDUT-1:0]      passOut;
  logic [NDUT-1:0][2:0] errCount;
  logic [NDUT-1:0][3:0] failMask;
  logic [NDUT-1:0][6:0] gateIn;
`ifdef GATE_CHK_CAPTURE_EN
  logic [NDUT-1:0][1:0] firstVec;
  logic [NDUT-1:0][6:0] firstSyn;
`endif

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  function automatic int settleOf(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 5);
  endfunction

  // Truth of each gate from integer arithmetic on the input vector v = {a,b}
  function automatic logic [6:0] goldGates(input int v);
    int a;
    int b;
    int andV;
    int orV;
    int xorV;
    logic [6:0] r;
    a    = v / 2;
    b    = v % 2;
    andV = a * b;
    orV  = (a + b > 0) ? 1 : 0;
    xorV = (a + b == 1) ? 1 : 0;
    r[0] = (b == 0);
    r[1] = (andV == 1);
    r[2] = (orV == 1);
    r[3] = (andV == 0);
    r[4] = (orV == 0);
    r[5] = (xorV == 1);
    r[6] = (xorV == 0);
    return r;
  endfunction

  function automatic logic [6:0] faultyGates(input int v, input logic [6:0] m, input logic [6:0] val);
    return (goldGates(v) & ~m) | (val & m);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 2 : 5);

    assign gateIn[g] = faultyGates(int'({aOut[g], bOut[g]}), forceMask, forceVal);

    gate_response_checker #(.SETTLE_CYCLES(S)) uDut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .gate_in   (gateIn[g]),
      .a_out     (aOut[g]),
      .b_out     (bOut[g]),
      .busy      (busyOut[g]),
      .done      (doneOut[g]),
      .pass      (passOut[g]),
      .err_count (errCount[g]),
      .fail_mask (failMask[g])
`ifdef GATE_CHK_CAPTURE_EN
      ,
      .first_fail_vec (firstVec[g]),
      .first_syndrome (firstSyn[g])
`endif
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleZero(input string where);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("%s dut%0d a_out", where, g), 32'(aOut[g]), 32'd0);
      checkOutput($sformatf("%s dut%0d b_out", where, g), 32'(bOut[g]), 32'd0);
      checkOutput($sformatf("%s dut%0d busy", where, g), 32'(busyOut[g]), 32'd0);
      checkOutput($sformatf("%s dut%0d done", where, g), 32'(doneOut[g]), 32'd0);
      checkOutput($sformatf("%s dut%0d pass", where, g), 32'(passOut[g]), 32'd0);
      checkOutput($sformatf("%s dut%0d err_count", where, g), 32'(errCount[g]), 32'd0);
      checkOutput($sformatf("%s dut%0d fail_mask", where, g), 32'(failMask[g]), 32'd0);
`ifdef GATE_CHK_CAPTURE_EN
      checkOutput($sformatf("%s dut%0d first_fail_vec", where, g), 32'(firstVec[g]), 32'd0);
      checkOutput($sformatf("%s dut%0d first_syndrome", where, g), 32'(firstSyn[g]), 32'd0);
`endif
    end
  endtask

  // Expected outputs of checker g in cycle n of a sweep (cycle 1 follows the start edge)
  task automatic checkCycle(input int g, input int n);
    int per;
    int doneC;
    int v;
    int cnt;
    int firstV;
    logic eA;
    logic eB;
    logic eBusy;
    logic found;
    logic [3:0] mask;
    logic [6:0] syn;
    per   = settleOf(g) + 1;
    doneC = 4 * per + 1;
    if (n <= 4 * per) begin
      v     = (n - 1) / per;
      eA    = (v / 2) == 1;
      eB    = (v % 2) == 1;
      eBusy = 1'b1;
    end else begin
      eA    = 1'b0;
      eB    = 1'b0;
      eBusy = 1'b0;
    end
    cnt    = 0;
    mask   = 4'd0;
    found  = 1'b0;
    firstV = 0;
    syn    = 7'd0;
    for (int k = 0; k < 4; k++) begin
      if (((k + 1) * per < n) && (faultyGates(k, forceMask, forceVal) !== goldGates(k))) begin
        mask[k] = 1'b1;
        cnt++;
        if (!found) begin
          found  = 1'b1;
          firstV = k;
          syn    = faultyGates(k, forceMask, forceVal) ^ goldGates(k);
        end
      end
    end
    checkOutput($sformatf("dut%0d c%0d a_out", g, n), 32'(aOut[g]), 32'(eA));
    checkOutput($sformatf("dut%0d c%0d b_out", g, n), 32'(bOut[g]), 32'(eB));
    checkOutput($sformatf("dut%0d c%0d busy", g, n), 32'(busyOut[g]), 32'(eBusy));
    checkOutput($sformatf("dut%0d c%0d done", g, n), 32'(doneOut[g]), (n == doneC) ? 32'd1 : 32'd0);
    checkOutput($sformatf("dut%0d c%0d pass", g, n), 32'(passOut[g]),
                ((n >= doneC) && (cnt == 0)) ? 32'd1 : 32'd0);
    checkOutput($sformatf("dut%0d c%0d err_count", g, n), 32'(errCount[g]), 32'(cnt));
    checkOutput($sformatf("dut%0d c%0d fail_mask", g, n), 32'(failMask[g]), 32'(mask));
`ifdef GATE_CHK_CAPTURE_EN
    checkOutput($sformatf("dut%0d c%0d first_fail_vec", g, n), 32'(firstVec[g]), 32'(firstV));
    checkOutput($sformatf("dut%0d c%0d first_syndrome", g, n), 32'(firstSyn[g]), 32'(syn));
`endif
  endtask

  // One sweep on all checkers; inject re-pulses start while they are busy or in done
  task automatic applyStimulus(input logic inject);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= LASTCYC; n++) begin
      for (int g = 0; g < NDUT; g++) begin
        checkCycle(g, n);
      end
      start = inject && ((n == 3) || (n == 8) || (n == 9));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    forceMask = 7'h00;
    forceVal  = 7'h00;
    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdleZero("idle");

    $display("[TB] fault-free sweep");
    applyStimulus(1'b0);

    $display("[TB] and output stuck at 0");
    forceMask = 7'h02;
    forceVal  = 7'h00;
    applyStimulus(1'b0);

    $display("[TB] gate_in held at 0");
    forceMask = 7'h7F;
    applyStimulus(1'b0);

    $display("[TB] extra start pulses during sweep");
    forceMask = 7'h00;
    applyStimulus(1'b1);

    $display("[TB] reset mid-sweep");
    forceMask = 7'h7F;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkIdleZero("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        checkOutput($sformatf("postreset dut%0d c%0d done", g, n), 32'(doneOut[g]), 32'd0);
        checkOutput($sformatf("postreset dut%0d c%0d busy", g, n), 32'(busyOut[g]), 32'd0);
      end
    end
    forceMask = 7'h00;
    applyStimulus(1'b0);

    $display("[TB] random fault patterns");
    for (int r = 0; r < 8; r++) begin
      forceMask = 7'($urandom);
      forceVal  = 7'($urandom);
      applyStimulus(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
